// File: rtl/dual_mem_pipe.sv
// Simple dual-port RAM with one write port and one read port, both on clk.
// Latency: read data 1 cycle after rd_fire, or 2 cycles with DPRAM_OUTREG_EN defined.
// Backpressure: none; both ports accept a request every cycle, and reads stream at full rate.
//
// Optional build macro:
//   DPRAM_OUTREG_EN  adds an output register stage. Data and all status pulses
//                    are delayed together, so they stay aligned.
//
// Ports:
//   clk, rst      clock (rising edge) and asynchronous active-high reset
//   mem_en/write  write request; wr_address, data_in, wr_be (one bit per byte lane)
//   op_en/read    read request; rd_address
//   data_out      registered read data; it holds its value between reads
//   rd_valid      one-cycle pulse while data_out carries a fresh read result
//   collision     pulse aligned with rd_valid; the read hit the same-cycle write
//   addr_err      pulse; a read or write used an address >= RAM_DEPTH
module dual_mem_pipe #(
  parameter int RAM_WIDTH = 64,
  parameter int RAM_DEPTH = 1024,
  parameter int ADDR_SIZE = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_en,
  input  logic                 write,
  input  logic [ADDR_SIZE-1:0] wr_address,
  input  logic [RAM_WIDTH-1:0] data_in,
  input  logic [RAM_WIDTH/8-1:0] wr_be,
  input  logic                 op_en,
  input  logic                 read,
  input  logic [ADDR_SIZE-1:0] rd_address,
  output logic [RAM_WIDTH-1:0] data_out,
  output logic                 rd_valid,
  output logic                 collision,
  output logic                 addr_err
);

  localparam int BE_W = RAM_WIDTH / 8;

  // The range check is done one bit wider than the address. This keeps the
  // comparison meaningful when RAM_DEPTH equals 2**ADDR_SIZE.
  localparam logic [ADDR_SIZE:0] DEPTH_L = (ADDR_SIZE + 1)'(RAM_DEPTH);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

  logic                 wr_fire;
  logic                 rd_fire;
  logic                 wr_ok;
  logic                 rd_ok;
  logic                 addr_hit;
  logic                 col_next;
  logic                 err_next;
  logic [RAM_WIDTH-1:0] rd_word;
  logic [RAM_WIDTH-1:0] rd_next;

  // First output stage. This stage drives the outputs unless the optional
  // output register is enabled.
  logic [RAM_WIDTH-1:0] data_s1;
  logic                 vld_s1;
  logic                 col_s1;
  logic                 err_s1;

  assign wr_fire = mem_en & write;
  assign rd_fire = op_en & read;
  assign wr_ok   = ({1'b0, wr_address} < DEPTH_L);
  assign rd_ok   = ({1'b0, rd_address} < DEPTH_L);

  // A write can only bypass into a read when both addresses are real locations.
  assign addr_hit = wr_fire & wr_ok & rd_ok & (rd_address == wr_address);
  assign col_next = rd_fire & addr_hit;

  // Read and write errors in the same cycle give a single pulse.
  assign err_next = (rd_fire & ~rd_ok) | (wr_fire & ~wr_ok);

  // Storage. It has no reset. A write is blocked when its address is out of range.
  always_ff @(posedge clk) begin
    if (wr_fire && wr_ok) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wr_be[i]) begin
          mem[wr_address][8*i +: 8] <= data_in[8*i +: 8];
        end
      end
    end
  end

  // Write-first merge. When the read hits the write address, each enabled lane
  // returns the incoming byte and each disabled lane returns the stored byte.
  // An out-of-range read returns zero, so the stale array output is never used.
  always_comb begin
    rd_word = '0;
    rd_next = '0;
    if (rd_ok) begin
      rd_word = mem[rd_address];
      rd_next = rd_word;
      for (int i = 0; i < BE_W; i++) begin
        if (addr_hit && wr_be[i]) begin
          rd_next[8*i +: 8] = data_in[8*i +: 8];
        end
      end
    end
  end

  // data_s1 loads only on a read, so data_out holds between reads. Reset
  // clears the valid bit, which drops any read still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_s1 <= '0;
      vld_s1  <= 1'b0;
      col_s1  <= 1'b0;
      err_s1  <= 1'b0;
    end else begin
      vld_s1 <= rd_fire;
      col_s1 <= col_next;
      err_s1 <= err_next;
      if (rd_fire) begin
        data_s1 <= rd_next;
      end
    end
  end

`ifdef DPRAM_OUTREG_EN
  logic [RAM_WIDTH-1:0] data_s2;
  logic                 vld_s2;
  logic                 col_s2;
  logic                 err_s2;

  // Extra retiming stage. The status bits move with the data, so alignment is
  // unchanged and a new read can still be accepted every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_s2 <= '0;
      vld_s2  <= 1'b0;
      col_s2  <= 1'b0;
      err_s2  <= 1'b0;
    end else begin
      vld_s2 <= vld_s1;
      col_s2 <= col_s1;
      err_s2 <= err_s1;
      if (vld_s1) begin
        data_s2 <= data_s1;
      end
    end
  end

  assign data_out  = data_s2;
  assign rd_valid  = vld_s2;
  assign collision = col_s2;
  assign addr_err  = err_s2;
`else
  assign data_out  = data_s1;
  assign rd_valid  = vld_s1;
  assign collision = col_s1;
  assign addr_err  = err_s1;
`endif

endmodule

// File: tb/tb_dual_mem_pipe.sv
// Self-checking bench for dual_mem_pipe with RAM_DEPTH=1000.
// The table vectors cover the directed cases. A reference model checks every cycle.
module tb_dual_mem_pipe;

  localparam int W = 64;
  localparam int D = 1000;
  localparam int A = 10;
`ifdef DPRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           mem_en, write, op_en, read;
  logic [A-1:0]   wr_address, rd_address;
  logic [W-1:0]   data_in;
  logic [W/8-1:0] wr_be;
  logic [W-1:0]   data_out;
  logic           rd_valid, collision, addr_err;

  dual_mem_pipe #(.RAM_WIDTH(W), .RAM_DEPTH(D), .ADDR_SIZE(A)) dut (
    .clk(clk), .rst(rst),
    .mem_en(mem_en), .write(write), .wr_address(wr_address),
    .data_in(data_in), .wr_be(wr_be),
    .op_en(op_en), .read(read), .rd_address(rd_address),
    .data_out(data_out), .rd_valid(rd_valid),
    .collision(collision), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the memory is a plain word array. Each cycle's expected
  // result waits in a queue for LAT cycles.
  typedef struct {
    logic       vld, col, err, dk;
    logic [W-1:0] data;
  } exp_t;
  exp_t         q[$];
  logic [W-1:0] mmem [0:1023];
  bit           mknown [0:1023];
  logic [W-1:0] last_data;
  bit           last_known;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic me, input logic wr, input logic [A-1:0] wa,
                     input logic [W-1:0] di, input logic [7:0] be,
                     input logic oe, input logic rd, input logic [A-1:0] ra);
    exp_t r;
    bit rf, wf, rok, wok;
    mem_en = me; write = wr; wr_address = wa; data_in = di; wr_be = be;
    op_en = oe; read = rd; rd_address = ra;
    rf  = me ? 1'b0 : 1'b0;
    rf  = oe && rd;
    wf  = me && wr;
    rok = int'(ra) < D;
    wok = int'(wa) < D;
    r.vld = rf;
    r.err = (rf && !rok) || (wf && !wok);
    r.col = rf && wf && rok && wok && (ra == wa);
    if (!rok) begin
      r.data = '0;
      r.dk   = 1'b1;
    end else begin
      r.data = mmem[ra];
      r.dk   = mknown[ra];
      if (r.col) begin
        for (int i = 0; i < 8; i++) if (be[i]) r.data[8*i +: 8] = di[8*i +: 8];
        if (be == 8'hFF) r.dk = 1'b1;
      end
    end
    if (wf && wok) begin
      for (int i = 0; i < 8; i++) if (be[i]) mmem[wa][8*i +: 8] = di[8*i +: 8];
      if (be == 8'hFF) mknown[wa] = 1'b1;
    end
    q.push_back(r);
    @(posedge clk);
    @(negedge clk);
    if (q.size() == LAT) begin
      r = q.pop_front();
      if (r.vld) begin
        last_data  = r.data;
        last_known = r.dk;
      end
      chk("model rd_valid", W'(rd_valid), W'(r.vld));
      chk("model collision", W'(collision), W'(r.col));
      chk("model addr_err", W'(addr_err), W'(r.err));
      if (last_known) chk("model data_out", data_out, last_data);
    end
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  typedef struct {
    logic me, wr; logic [A-1:0] wa; logic [W-1:0] di; logic [7:0] be;
    logic oe, rd; logic [A-1:0] ra;
    logic [W-1:0] ed; logic ev, ec, ee;
  } vec_t;
  vec_t tbl[$];

  task automatic addv(input logic me, input logic wr, input logic [A-1:0] wa,
                      input logic [W-1:0] di, input logic [7:0] be,
                      input logic oe, input logic rd, input logic [A-1:0] ra,
                      input logic [W-1:0] ed, input logic ev, input logic ec, input logic ee);
    vec_t v;
    v.me = me; v.wr = wr; v.wa = wa; v.di = di; v.be = be;
    v.oe = oe; v.rd = rd; v.ra = ra; v.ed = ed; v.ev = ev; v.ec = ec; v.ee = ee;
    tbl.push_back(v);
  endtask

  initial begin
    logic [A-1:0] ra, wa;
    logic [W-1:0] d;

    // Directed vectors. Later rows depend on the memory state left by earlier rows.
    addv(1,1,10'd5,   64'h0123456789ABCDEF,8'hFF, 0,0,10'd0,   64'h0,                0,0,0);
    addv(0,0,10'd0,   64'h0,               8'h00, 1,1,10'd5,   64'h0123456789ABCDEF, 1,0,0);
    addv(1,1,10'd5,   64'hFFFFFFFFFFFFFFFF,8'h0F, 0,0,10'd0,   64'h0,                0,0,0);
    addv(0,0,10'd0,   64'h0,               8'h00, 1,1,10'd5,   64'h01234567FFFFFFFF, 1,0,0);
    addv(1,1,10'd7,   64'h0,               8'hFF, 0,0,10'd0,   64'h0,                0,0,0);
    addv(1,1,10'd7,   64'hAAAAAAAAAAAAAAAA,8'hF0, 1,1,10'd7,   64'hAAAAAAAA00000000, 1,1,0);
    addv(1,1,10'd1000,64'h55,              8'hFF, 1,1,10'd1000,64'h0,                1,0,1);
    addv(0,0,10'd0,   64'h0,               8'h00, 1,1,10'd5,   64'h01234567FFFFFFFF, 1,0,0);
    addv(1,1,10'd999, 64'h99,              8'hFF, 0,0,10'd0,   64'h0,                0,0,0);
    addv(0,0,10'd0,   64'h0,               8'h00, 1,1,10'd999, 64'h99,               1,0,0);
    addv(1,1,10'd1023,64'h1234,            8'hFF, 0,0,10'd0,   64'h0,                0,0,1);
    addv(0,0,10'd0,   64'h0,               8'h00, 1,1,10'd999, 64'h99,               1,0,0);
    addv(0,1,10'd5,   64'h0,               8'hFF, 0,0,10'd0,   64'h0,                0,0,0);
    addv(0,0,10'd0,   64'h0,               8'h00, 1,1,10'd5,   64'h01234567FFFFFFFF, 1,0,0);
    addv(0,0,10'd0,   64'h0,               8'h00, 0,1,10'd5,   64'h0,                0,0,0);
    addv(1,1,10'd7,   64'hFFFFFFFFFFFFFFFF,8'h00, 1,1,10'd7,   64'hAAAAAAAA00000000, 1,1,0);
    addv(0,0,10'd0,   64'h0,               8'h00, 1,1,10'd7,   64'hAAAAAAAA00000000, 1,0,0);
    addv(1,1,10'd0,   64'h11,              8'hFF, 1,1,10'd1000,64'h0,                1,0,1);
    addv(0,0,10'd0,   64'h0,               8'h00, 1,1,10'd0,   64'h11,               1,0,0);

    // Reset state
    rst = 1'b1;
    mem_en = 0; write = 0; wr_address = '0; data_in = '0; wr_be = '0;
    op_en = 0; read = 0; rd_address = '0;
    for (int i = 0; i < 1024; i++) begin mmem[i] = '0; mknown[i] = 1'b0; end
    last_data = '0; last_known = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset data_out", data_out, '0);
    chk("reset rd_valid", W'(rd_valid), '0);
    chk("reset collision", W'(collision), '0);
    chk("reset addr_err", W'(addr_err), '0);
    rst = 1'b0;

    // Table-driven vectors
    foreach (tbl[k]) begin
      cyc(tbl[k].me, tbl[k].wr, tbl[k].wa, tbl[k].di, tbl[k].be,
          tbl[k].oe, tbl[k].rd, tbl[k].ra);
      for (int j = 0; j < LAT - 1; j++) idle();
      chk($sformatf("tbl[%0d] rd_valid", k), W'(rd_valid), W'(tbl[k].ev));
      chk($sformatf("tbl[%0d] collision", k), W'(collision), W'(tbl[k].ec));
      chk($sformatf("tbl[%0d] addr_err", k), W'(addr_err), W'(tbl[k].ee));
      if (tbl[k].ev) chk($sformatf("tbl[%0d] data_out", k), data_out, tbl[k].ed);
    end

    // Streaming: fill 0..15, then read back-to-back, then hold with op_en low
    for (int i = 0; i < 16; i++) cyc(1, 1, A'(i), W'(i), 8'hFF, 0, 0, '0);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, '0, '0, '0, 1, 1, A'(i));
      if (i >= LAT - 1) begin
        chk($sformatf("stream rd_valid %0d", i), W'(rd_valid), W'(1));
        chk($sformatf("stream data %0d", i), data_out, W'(i - (LAT - 1)));
      end
    end
    for (int k = 0; k < LAT - 1; k++) begin
      cyc(0, 0, '0, '0, '0, 0, 1, '0);
      chk("stream tail rd_valid", W'(rd_valid), W'(1));
      chk("stream tail data", data_out, W'(16 - (LAT - 1) + k));
    end
    repeat (2) begin
      cyc(0, 0, '0, '0, '0, 0, 1, '0);
      chk("hold rd_valid", W'(rd_valid), '0);
      chk("hold data_out", data_out, W'(15));
    end

    // Reset asserted while a read is in flight
    cyc(0, 0, '0, '0, '0, 1, 1, A'(5));
    rst = 1'b1;
    idle_inputs();
    #1;
    chk("midrst data_out", data_out, '0);
    chk("midrst rd_valid", W'(rd_valid), '0);
    q.delete();
    last_data = '0; last_known = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrst hold rd_valid", W'(rd_valid), '0);
    chk("midrst hold data_out", data_out, '0);
    rst = 1'b0;
    repeat (4) idle();

    // Randomized traffic: first fill every word, then run mixed accesses
    for (int a = 0; a < D; a++) cyc(1, 1, A'(a), {$urandom, $urandom}, 8'hFF, 0, 0, '0);
    for (int n = 0; n < 2000; n++) begin
      ra = ($urandom_range(0, 9) == 0) ? A'($urandom_range(1000, 1023)) : A'($urandom_range(0, 31));
      wa = ($urandom_range(0, 9) < 3) ? ra :
           (($urandom_range(0, 9) == 0) ? A'($urandom_range(1000, 1023)) : A'($urandom_range(0, 31)));
      d = {$urandom, $urandom};
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, wa, d, 8'($urandom),
          $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, ra);
    end
    repeat (LAT) idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic idle_inputs();
    mem_en = 0; write = 0; op_en = 0; read = 0;
  endtask

endmodule
